// File: rtl/axi_lite_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axi_lite_arbiter : two-master AXI4-Lite arbiter, one transaction at a time,
//                    round-robin between masters.
// Revision: 1.0
// ---------------------------------------------------------------------------
module axi_lite_arbiter #(
  parameter bit RD_FIRST = 1'b1
) (
  input  logic        aclk,
  input  logic        areset_n,
  // upstream master 0
  input  logic [31:0] s0_awaddr,
  input  logic        s0_awvalid,
  output logic        s0_awready,
  input  logic [31:0] s0_wdata,
  input  logic [3:0]  s0_wstrb,
  input  logic        s0_wvalid,
  output logic        s0_wready,
  output logic [1:0]  s0_bresp,
  output logic        s0_bvalid,
  input  logic        s0_bready,
  input  logic [31:0] s0_araddr,
  input  logic        s0_arvalid,
  output logic        s0_arready,
  output logic [31:0] s0_rdata,
  output logic [1:0]  s0_rresp,
  output logic        s0_rvalid,
  input  logic        s0_rready,
  // upstream master 1
  input  logic [31:0] s1_awaddr,
  input  logic        s1_awvalid,
  output logic        s1_awready,
  input  logic [31:0] s1_wdata,
  input  logic [3:0]  s1_wstrb,
  input  logic        s1_wvalid,
  output logic        s1_wready,
  output logic [1:0]  s1_bresp,
  output logic        s1_bvalid,
  input  logic        s1_bready,
  input  logic [31:0] s1_araddr,
  input  logic        s1_arvalid,
  output logic        s1_arready,
  output logic [31:0] s1_rdata,
  output logic [1:0]  s1_rresp,
  output logic        s1_rvalid,
  input  logic        s1_rready,
  // downstream shared slave
  output logic [31:0] m_awaddr,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready,
  output logic [31:0] m_araddr,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rvalid,
  output logic        m_rready,
  // status
  output logic [1:0]  gnt,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   owner_q, owner_d;
  logic   rr_last_q, rr_last_d;

  logic req0, req1, win, win_ar, win_aw;
  logic rd_act, wr_act;
  logic rd0, rd1, wr0, wr1;

  assign req0   = s0_arvalid | s0_awvalid;
  assign req1   = s1_arvalid | s1_awvalid;
  // on a contest the master that was not served last wins
  assign win    = (req0 && req1) ? ~rr_last_q : req1;
  assign win_ar = win ? s1_arvalid : s0_arvalid;
  assign win_aw = win ? s1_awvalid : s0_awvalid;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_last_d = rr_last_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          owner_d = win;
          state_d = (win_ar && (!win_aw || RD_FIRST)) ? RD : WR;
        end
      end
      RD: begin
        if (m_rvalid && m_rready) begin
          state_d   = IDLE;
          rr_last_d = owner_q;
        end
      end
      WR: begin
        if (m_bvalid && m_bready) begin
          state_d   = IDLE;
          rr_last_d = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      rr_last_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
    end
  end

  // all routing is decoded from registered state so reset drops it at once
  assign rd_act = (state_q == RD);
  assign wr_act = (state_q == WR);
  assign rd0    = rd_act & ~owner_q;
  assign rd1    = rd_act &  owner_q;
  assign wr0    = wr_act & ~owner_q;
  assign wr1    = wr_act &  owner_q;

  assign gnt  = {rd1 | wr1, rd0 | wr0};
  assign busy = rd_act | wr_act;

  assign m_araddr  = rd0 ? s0_araddr  : (rd1 ? s1_araddr  : '0);
  assign m_arvalid = rd0 ? s0_arvalid : (rd1 ? s1_arvalid : 1'b0);
  assign m_rready  = rd0 ? s0_rready  : (rd1 ? s1_rready  : 1'b0);
  assign m_awaddr  = wr0 ? s0_awaddr  : (wr1 ? s1_awaddr  : '0);
  assign m_awvalid = wr0 ? s0_awvalid : (wr1 ? s1_awvalid : 1'b0);
  assign m_wdata   = wr0 ? s0_wdata   : (wr1 ? s1_wdata   : '0);
  assign m_wstrb   = wr0 ? s0_wstrb   : (wr1 ? s1_wstrb   : '0);
  assign m_wvalid  = wr0 ? s0_wvalid  : (wr1 ? s1_wvalid  : 1'b0);
  assign m_bready  = wr0 ? s0_bready  : (wr1 ? s1_bready  : 1'b0);

  assign s0_arready = rd0 & m_arready;
  assign s0_rvalid  = rd0 & m_rvalid;
  assign s0_rdata   = rd0 ? m_rdata : '0;
  assign s0_rresp   = rd0 ? m_rresp : '0;
  assign s0_awready = wr0 & m_awready;
  assign s0_wready  = wr0 & m_wready;
  assign s0_bvalid  = wr0 & m_bvalid;
  assign s0_bresp   = wr0 ? m_bresp : '0;

  assign s1_arready = rd1 & m_arready;
  assign s1_rvalid  = rd1 & m_rvalid;
  assign s1_rdata   = rd1 ? m_rdata : '0;
  assign s1_rresp   = rd1 ? m_rresp : '0;
  assign s1_awready = wr1 & m_awready;
  assign s1_wready  = wr1 & m_wready;
  assign s1_bvalid  = wr1 & m_bvalid;
  assign s1_bresp   = wr1 ? m_bresp : '0;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_axi_lite_arbiter : directed bench for axi_lite_arbiter with a small
//                       register-slave model.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_axi_lite_arbiter;
    logic clk = 1'b0;
    logic areset_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int bstall = 0;

    logic [31:0] u_awaddr [2];
    logic [31:0] u_wdata  [2];
    logic [31:0] u_araddr [2];
    logic [1:0]  u_awvalid, u_wvalid, u_bready, u_arvalid, u_rready;
    wire  [1:0]  u_awready, u_wready, u_bvalid, u_arready, u_rvalid;
    wire  [1:0]  u_bresp [2];
    wire  [1:0]  u_rresp [2];
    wire  [31:0] u_rdata [2];

    wire  [31:0] m_awaddr, m_wdata, m_araddr;
    wire  [3:0]  m_wstrb;
    wire         m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
    logic        m_awready, m_wready, m_bvalid, m_arready, m_rvalid;
    logic [1:0]  m_bresp, m_rresp;
    logic [31:0] m_rdata;
    wire  [1:0]  gnt;
    wire         busy;

    wire         wf_s0_awready, wf_s0_wready, wf_s0_bvalid, wf_s0_arready, wf_s0_rvalid;
    wire         wf_s1_awready, wf_s1_wready, wf_s1_bvalid, wf_s1_arready, wf_s1_rvalid;
    wire  [1:0]  wf_s0_bresp, wf_s0_rresp, wf_s1_bresp, wf_s1_rresp, wf_gnt;
    wire  [31:0] wf_s0_rdata, wf_s1_rdata, wf_m_awaddr, wf_m_wdata, wf_m_araddr;
    wire  [3:0]  wf_m_wstrb;
    wire         wf_m_awvalid, wf_m_wvalid, wf_m_bready, wf_m_arvalid, wf_m_rready, wf_busy;

    axi_lite_arbiter #(.RD_FIRST(1'b1)) u_dut (
        .aclk(clk), .areset_n(areset_n),
        .s0_awaddr(u_awaddr[0]), .s0_awvalid(u_awvalid[0]), .s0_awready(u_awready[0]),
        .s0_wdata(u_wdata[0]), .s0_wstrb(4'hF), .s0_wvalid(u_wvalid[0]), .s0_wready(u_wready[0]),
        .s0_bresp(u_bresp[0]), .s0_bvalid(u_bvalid[0]), .s0_bready(u_bready[0]),
        .s0_araddr(u_araddr[0]), .s0_arvalid(u_arvalid[0]), .s0_arready(u_arready[0]),
        .s0_rdata(u_rdata[0]), .s0_rresp(u_rresp[0]), .s0_rvalid(u_rvalid[0]), .s0_rready(u_rready[0]),
        .s1_awaddr(u_awaddr[1]), .s1_awvalid(u_awvalid[1]), .s1_awready(u_awready[1]),
        .s1_wdata(u_wdata[1]), .s1_wstrb(4'hF), .s1_wvalid(u_wvalid[1]), .s1_wready(u_wready[1]),
        .s1_bresp(u_bresp[1]), .s1_bvalid(u_bvalid[1]), .s1_bready(u_bready[1]),
        .s1_araddr(u_araddr[1]), .s1_arvalid(u_arvalid[1]), .s1_arready(u_arready[1]),
        .s1_rdata(u_rdata[1]), .s1_rresp(u_rresp[1]), .s1_rvalid(u_rvalid[1]), .s1_rready(u_rready[1]),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .gnt(gnt), .busy(busy)
    );

    axi_lite_arbiter #(.RD_FIRST(1'b0)) u_dut_wf (
        .aclk(clk), .areset_n(areset_n),
        .s0_awaddr(u_awaddr[0]), .s0_awvalid(u_awvalid[0]), .s0_awready(wf_s0_awready),
        .s0_wdata(u_wdata[0]), .s0_wstrb(4'hF), .s0_wvalid(u_wvalid[0]), .s0_wready(wf_s0_wready),
        .s0_bresp(wf_s0_bresp), .s0_bvalid(wf_s0_bvalid), .s0_bready(u_bready[0]),
        .s0_araddr(u_araddr[0]), .s0_arvalid(u_arvalid[0]), .s0_arready(wf_s0_arready),
        .s0_rdata(wf_s0_rdata), .s0_rresp(wf_s0_rresp), .s0_rvalid(wf_s0_rvalid), .s0_rready(u_rready[0]),
        .s1_awaddr(u_awaddr[1]), .s1_awvalid(u_awvalid[1]), .s1_awready(wf_s1_awready),
        .s1_wdata(u_wdata[1]), .s1_wstrb(4'hF), .s1_wvalid(u_wvalid[1]), .s1_wready(wf_s1_wready),
        .s1_bresp(wf_s1_bresp), .s1_bvalid(wf_s1_bvalid), .s1_bready(u_bready[1]),
        .s1_araddr(u_araddr[1]), .s1_arvalid(u_arvalid[1]), .s1_arready(wf_s1_arready),
        .s1_rdata(wf_s1_rdata), .s1_rresp(wf_s1_rresp), .s1_rvalid(wf_s1_rvalid), .s1_rready(u_rready[1]),
        .m_awaddr(wf_m_awaddr), .m_awvalid(wf_m_awvalid), .m_awready(m_awready),
        .m_wdata(wf_m_wdata), .m_wstrb(wf_m_wstrb), .m_wvalid(wf_m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(wf_m_bready),
        .m_araddr(wf_m_araddr), .m_arvalid(wf_m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(wf_m_rready),
        .gnt(wf_gnt), .busy(wf_busy)
    );

    // register slave: 16 words, B response delayed by bstall cycles
    logic [31:0] mem [16];
    logic        aw_got, w_got;
    logic [3:0]  aw_idx;
    logic [31:0] w_dat;
    int          cnt;
    assign m_arready = 1'b1;
    assign m_awready = ~aw_got;
    assign m_wready  = ~w_got;
    assign m_bresp   = 2'b00;
    assign m_rresp   = 2'b00;

    always @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            for (int k = 0; k < 16; k++) mem[k] <= 32'h0;
            mem[1]  <= 32'hDEADBEEF;
            m_rvalid <= 1'b0; m_bvalid <= 1'b0; m_rdata <= 32'h0;
            aw_got <= 1'b0; w_got <= 1'b0; aw_idx <= 4'h0; w_dat <= 32'h0; cnt <= 0;
        end else begin
            if (m_arvalid && m_arready) begin
                m_rdata  <= mem[m_araddr[5:2]];
                m_rvalid <= 1'b1;
            end else if (m_rvalid && m_rready) m_rvalid <= 1'b0;
            if (m_awvalid && m_awready) begin aw_got <= 1'b1; aw_idx <= m_awaddr[5:2]; end
            if (m_wvalid && m_wready) begin w_got <= 1'b1; w_dat <= m_wdata; end
            if (aw_got && w_got && !m_bvalid) begin
                if (cnt == bstall) begin
                    mem[aw_idx] <= w_dat; m_bvalid <= 1'b1; cnt <= 0;
                    aw_got <= 1'b0; w_got <= 1'b0;
                end else cnt <= cnt + 1;
            end
            if (m_bvalid && m_bready) m_bvalid <= 1'b0;
        end
    end

    // every change of gnt: {gnt, m_arvalid, m_awvalid}
    logic [3:0] log_q [$];
    logic [1:0] prev_gnt = 2'b00;
    always @(negedge clk) begin
        if (gnt !== prev_gnt) begin
            log_q.push_back({gnt, m_arvalid, m_awvalid});
            prev_gnt <= gnt;
        end
    end

    function automatic logic [3:0] lg(input int k);
        if (k < log_q.size()) return log_q[k];
        return 4'bxxxx;
    endfunction

    task automatic rd(input int i, input logic [31:0] a, output logic [31:0] d);
        int n;
        u_araddr[i] = a; u_arvalid[i] = 1'b1; u_rready[i] = 1'b1; n = 0;
        do begin @(negedge clk); n++; end while (!u_arready[i] && n < 200);
        total++; if (n >= 200) begin bad++; $error("FAIL rd_ar_wait n=%0d", n); end
        @(posedge clk); #1 u_arvalid[i] = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!u_rvalid[i] && n < 200);
        total++; if (n >= 200) begin bad++; $error("FAIL rd_r_wait n=%0d", n); end
        d = u_rdata[i];
        @(posedge clk); #1 u_rready[i] = 1'b0;
    endtask

    task automatic wr(input int i, input logic [31:0] a, input logic [31:0] dat);
        int n;
        bit awd, wd, aw_now, w_now;
        u_awaddr[i] = a; u_wdata[i] = dat; u_awvalid[i] = 1'b1; u_wvalid[i] = 1'b1;
        u_bready[i] = 1'b1; awd = 0; wd = 0; n = 0;
        while (!(awd && wd) && n < 200) begin
            @(negedge clk); n++;
            aw_now = u_awvalid[i] && u_awready[i];
            w_now  = u_wvalid[i] && u_wready[i];
            @(posedge clk); #1;
            if (aw_now) begin u_awvalid[i] = 1'b0; awd = 1; end
            if (w_now)  begin u_wvalid[i]  = 1'b0; wd  = 1; end
        end
        total++; if (n >= 200) begin bad++; $error("FAIL wr_aw_w_wait n=%0d", n); end
        n = 0;
        do begin @(negedge clk); n++; end while (!u_bvalid[i] && n < 200);
        total++; if (n >= 200) begin bad++; $error("FAIL wr_b_wait n=%0d", n); end
        @(posedge clk); #1 u_bready[i] = 1'b0;
    endtask

    logic [31:0] d0, d1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        u_awvalid = '0; u_wvalid = '0; u_bready = '0; u_arvalid = '0; u_rready = '0;
        for (int k = 0; k < 2; k++) begin
            u_awaddr[k] = '0; u_wdata[k] = '0; u_araddr[k] = '0;
        end

        #12;
        total++; if (gnt !== 2'b00) begin bad++; $error("FAIL rst_gnt observed=%0h", gnt); end
        total++; if (busy !== 1'b0) begin bad++; $error("FAIL rst_busy observed=%0h", busy); end
        total++; if (m_arvalid !== 1'b0) begin bad++; $error("FAIL rst_m_arvalid observed=%0h", m_arvalid); end
        total++; if (m_rready !== 1'b0) begin bad++; $error("FAIL rst_m_rready observed=%0h", m_rready); end
        total++; if (m_bready !== 1'b0) begin bad++; $error("FAIL rst_m_bready observed=%0h", m_bready); end
        total++; if (u_arready[0] !== 1'b0) begin bad++; $error("FAIL rst_s0_arready observed=%0h", u_arready[0]); end
        @(negedge clk); areset_n = 1'b1;

        @(negedge clk);
        u_awaddr[1] = 32'h20; u_wdata[1] = 32'h55;
        u_awvalid[1] = 1'b1; u_wvalid[1] = 1'b1; u_bready[1] = 1'b1;
        @(negedge clk);
        total++; if (gnt !== 2'b10) begin bad++; $error("FAIL mw_gnt observed=%0h", gnt); end
        total++; if (m_awvalid !== 1'b1) begin bad++; $error("FAIL mw_m_awvalid observed=%0h", m_awvalid); end
        #2 areset_n = 1'b0;
        #1;
        total++; if (gnt !== 2'b00) begin bad++; $error("FAIL mw_rst_gnt observed=%0h", gnt); end
        total++; if (busy !== 1'b0) begin bad++; $error("FAIL mw_rst_busy observed=%0h", busy); end
        total++; if (m_awvalid !== 1'b0) begin bad++; $error("FAIL mw_rst_m_awvalid observed=%0h", m_awvalid); end
        total++; if (u_bvalid[1] !== 1'b0) begin bad++; $error("FAIL mw_rst_s1_bvalid observed=%0h", u_bvalid[1]); end
        u_awvalid[1] = 1'b0; u_wvalid[1] = 1'b0; u_bready[1] = 1'b0;
        @(negedge clk); areset_n = 1'b1;

        @(negedge clk);
        u_araddr[0] = 32'h4; u_arvalid[0] = 1'b1; u_rready[0] = 1'b1;
        #1;
        total++; if (gnt !== 2'b00) begin bad++; $error("FAIL sr_gnt_before observed=%0h", gnt); end
        @(negedge clk);
        total++; if (gnt !== 2'b01) begin bad++; $error("FAIL sr_gnt observed=%0h", gnt); end
        total++; if (busy !== 1'b1) begin bad++; $error("FAIL sr_busy observed=%0h", busy); end
        total++; if (m_araddr !== 32'h4) begin bad++; $error("FAIL sr_m_araddr observed=%0h", m_araddr); end
        total++; if (u_arready[0] !== 1'b1) begin bad++; $error("FAIL sr_s0_arready observed=%0h", u_arready[0]); end
        @(posedge clk); #1 u_arvalid[0] = 1'b0;
        @(negedge clk);
        total++; if (u_rvalid[0] !== 1'b1) begin bad++; $error("FAIL sr_rvalid observed=%0h", u_rvalid[0]); end
        total++; if (u_rdata[0] !== 32'hDEADBEEF) begin bad++; $error("FAIL sr_rdata observed=%0h", u_rdata[0]); end
        total++; if (u_rresp[0] !== 2'b00) begin bad++; $error("FAIL sr_rresp observed=%0h", u_rresp[0]); end
        total++; if (u_rvalid[1] !== 1'b0) begin bad++; $error("FAIL sr_s1_rvalid observed=%0h", u_rvalid[1]); end
        @(posedge clk); #1 u_rready[0] = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $error("FAIL sr_busy_after observed=%0h", busy); end

        @(negedge clk) areset_n = 1'b0;
        @(negedge clk) areset_n = 1'b1;
        log_q.delete();
        @(negedge clk);
        fork
            wr(0, 32'h8, 32'h1234);
            rd(1, 32'h8, d1);
        join
        @(negedge clk); #1;
        total++; if (d1 !== 32'h1234) begin bad++; $error("FAIL ct_rdata observed=%0h", d1); end
        total++; if (lg(0) !== 4'b0101) begin bad++; $error("FAIL ct_log0 observed=%0h", lg(0)); end
        total++; if (lg(1) !== 4'b0000) begin bad++; $error("FAIL ct_log1 observed=%0h", lg(1)); end
        total++; if (lg(2) !== 4'b1010) begin bad++; $error("FAIL ct_log2 observed=%0h", lg(2)); end
        total++; if (lg(3) !== 4'b0000) begin bad++; $error("FAIL ct_log3 observed=%0h", lg(3)); end

        log_q.delete();
        fork
            begin
                for (int k = 0; k < 3; k++) begin
                    rd(0, 32'h4, d0);
                    total++; if (d0 !== 32'hDEADBEEF) begin bad++; $error("FAIL rr_rdata observed=%0h", d0); end
                end
            end
            begin
                for (int k = 0; k < 3; k++) wr(1, 32'hC, 32'h100 + k);
            end
        join
        @(negedge clk); #1;
        total++; if (log_q.size() !== 12) begin bad++; $error("FAIL rr_log_size observed=%0d", log_q.size()); end
        for (int k = 0; k < 12; k++) begin
            logic [3:0] e;
            e = (k % 2 == 1) ? 4'b0000 : ((k % 4 == 0) ? 4'b0110 : 4'b1001);
            total++; if (lg(k) !== e) begin bad++; $error("FAIL rr_log[%0d] observed=%0h expected=%0h", k, lg(k), e); end
        end

        bstall = 5;
        log_q.delete();
        fork
            wr(0, 32'h10, 32'hAA);
            begin @(negedge clk); @(negedge clk); rd(1, 32'hC0, d1); end
            begin
                repeat (10) begin
                    @(negedge clk);
                    if (gnt == 2'b01) begin
                        total++; if (u_arready[1] !== 1'b0) begin bad++; $error("FAIL iso_s1_arready observed=%0h", u_arready[1]); end
                        total++; if (m_araddr === 32'hC0) begin bad++; $error("FAIL iso_m_araddr observed=%0h", m_araddr); end
                    end
                end
            end
        join
        @(negedge clk); #1;
        total++; if (lg(0) !== 4'b0101) begin bad++; $error("FAIL iso_log0 observed=%0h", lg(0)); end
        total++; if (lg(1) !== 4'b0000) begin bad++; $error("FAIL iso_log1 observed=%0h", lg(1)); end
        total++; if (lg(2) !== 4'b1010) begin bad++; $error("FAIL iso_log2 observed=%0h", lg(2)); end
        total++; if (lg(3) !== 4'b0000) begin bad++; $error("FAIL iso_log3 observed=%0h", lg(3)); end

        @(negedge clk) areset_n = 1'b0;
        @(negedge clk) areset_n = 1'b1;
        log_q.delete();
        @(negedge clk);
        fork
            rd(1, 32'h4, d1);
            wr(1, 32'h14, 32'h77);
            begin
                @(negedge clk);
                total++; if (wf_gnt !== 2'b10) begin bad++; $error("FAIL wf_gnt observed=%0h", wf_gnt); end
                total++; if (wf_m_awvalid !== 1'b1) begin bad++; $error("FAIL wf_m_awvalid observed=%0h", wf_m_awvalid); end
                total++; if (wf_m_arvalid !== 1'b0) begin bad++; $error("FAIL wf_m_arvalid observed=%0h", wf_m_arvalid); end
            end
        join
        @(negedge clk); #1;
        total++; if (d1 !== 32'hDEADBEEF) begin bad++; $error("FAIL sm_rdata observed=%0h", d1); end
        total++; if (lg(0) !== 4'b1010) begin bad++; $error("FAIL sm_log0 observed=%0h", lg(0)); end
        total++; if (lg(1) !== 4'b0000) begin bad++; $error("FAIL sm_log1 observed=%0h", lg(1)); end
        total++; if (lg(2) !== 4'b1001) begin bad++; $error("FAIL sm_log2 observed=%0h", lg(2)); end
        total++; if (lg(3) !== 4'b0000) begin bad++; $error("FAIL sm_log3 observed=%0h", lg(3)); end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/axi_lite_arbiter.md
# axi_lite_arbiter

Two-master AXI4-Lite arbiter that shares one downstream AXI4-Lite slave (the register/buffer slave) between two upstream requesters. It serialises whole transactions: exactly one read or one write is outstanding downstream at any time. Fairness between the two masters is round-robin. The block sits between the requesting masters (e.g. CPU bridge and DMA config engine) and the slave's `axi_lite_if.slave` port.

## Interface
- `RD_FIRST`, default 1: when one master presents both `arvalid` and `awvalid` in the same cycle, 1 grants the read first and 0 grants the write first.
- `aclk`  input  1  clock; all logic is on the rising edge.
- `areset_n`  input  1  reset, asynchronous assert, active-low.
- `s0_axi_lite`  `axi_lite_if.slave`  pkg widths (`addr_t`/`data_t`, 32-bit)  upstream master 0.
- `s1_axi_lite`  `axi_lite_if.slave`  pkg widths  upstream master 1.
- `m_axi_lite`  `axi_lite_if.master`  pkg widths  downstream shared slave.
- `gnt`  output  2  one-hot current owner; 2'b00 when idle.
- `busy`  output  1  a transaction is in progress downstream.

## Operation
- **State machine states:** `IDLE`, `RD` (read granted), `WR` (write granted).
- **Registered state:** state, `owner` (0/1), `rr_last` (last master served).
- **Request:** a master requests when `arvalid | awvalid` is asserted.
- **Arbitration in `IDLE`:**
  - If only one master requests, that master wins.
  - If both request, the master ≠ `rr_last` wins.
  - Within the winner, the read/write choice follows `RD_FIRST` when both valids are high; otherwise the single asserted valid decides.
  - The winner is registered. Next state is `RD` or `WR`.
  - No request: stay in `IDLE`.
- **`RD` state:**
  - Winner's AR and R channels connect combinationally to `m_axi_lite`: `araddr`/`arvalid` go down; `arready`, `rdata`, `rresp` and `rvalid` come up.
  - Winner's AW, W and B outputs are held inactive: `awready=0`, `wready=0`, `bvalid=0`.
  - Exit to `IDLE` on the downstream R handshake (`rvalid & rready`). `rr_last` is set to the owner.
- **`WR` state:**
  - Winner's AW, W and B channels connect combinationally; AR/R outputs are held inactive.
  - AW and W are forwarded independently. The block does not enforce AW-before-W ordering; the slave sequences them.
  - Exit to `IDLE` on the downstream B handshake (`bvalid & bready`). `rr_last` is set to the owner.
- **Losing / idle master:** every `*ready` output is 0, every `*valid` output is 0, and `rdata`, `rresp`, `bresp` are 0.
- **Downstream while `IDLE`:** all `m_axi_lite` valids are 0 and all `m_axi_lite` ready outputs (`rready`, `bready`) are 0. Address and data are driven 0.
- **Mid-transaction requests:** a request arriving mid-transaction waits. The held master's valid stays high per AXI rules; no reordering is applied.
- **Dropped valid:** if the granted master drops its valid before the handshake (an AXI violation), the block stays in the granted state. There is no timeout.

## Timing
- **Reset (asynchronous, `areset_n=0`):** state=`IDLE`, `rr_last`=1 so master 0 has priority on the first contest, `gnt=0`, `busy=0`, all upstream and downstream outputs 0.
- **Arbitration latency:** 1 cycle. A request seen in `IDLE` at edge N yields `gnt`/`busy` and forwarded valids from edge N+1.
- **Forwarding:** the data path adds no cycles.
- **Turnaround:** the completing handshake at edge M returns the block to `IDLE` at M. The earliest next grant is visible after edge M+1, so back-to-back transactions have a minimum 1 idle cycle between them.
- **Simultaneous requests on the completing edge:** arbitration uses the updated `rr_last` (the other master wins if it requests).
- **Reset mid-transaction:** the block returns to `IDLE` immediately. Upstream and downstream valid/ready outputs drop asynchronously.
- **Status outputs:** `gnt` and `busy` are decoded from registered state only (glitch-free).

## Test plan
- **Reset:** hold `areset_n=0` mid-`WR` → `gnt=0`, `busy=0`, `m_axi_lite.awvalid=0`, `s1` `bvalid=0` without waiting for a clock edge.
- **Single read:** M0 read `araddr=0x4` while slave holds `0xDEADBEEF` → `gnt=2'b01` one cycle later; M0 sees `rdata=0xDEADBEEF`, `rresp=OKAY`; `busy` falls after the R handshake.
- **Simultaneous contest:** M0 write (`0x8` ← `0x1234`) and M1 read `0x8` both asserted from reset → M0 served first (write), then M1 (read) returning `0x1234`; `gnt` sequence 01, 00, 10.
- **Round-robin fairness:** both masters request continuously for 6 transactions → grants alternate 0,1,0,1,0,1; neither master starves.
- **Same-master read+write:** M1 asserts `arvalid` and `awvalid` together with `RD_FIRST=1` → read granted first, write on the next grant; with `RD_FIRST=0` the order reverses.
- **Isolation:** while M0 owns `WR` and the slave stalls `bvalid` for 5 cycles → M1 `arready=0` throughout and M1's `araddr` never appears on `m_axi_lite`.
